seg7_scan_driver: RTL

Parametrised, time-multiplexed 7-segment display driver: the successor to our parallel per-digit BCD decoder. It drives DIGITS digits over one shared segment bus with one-hot anode scanning. It adds hexadecimal mode, leading-zero blanking, per-digit decimal points, per-digit blink and an inter-digit dead time. It sits between the clock/counter datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_encode.sv | 19 +
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high segment codes.
// Latency: n/a (constants and a pure lookup function).
// Backpressure: n/a.
package seg7_pkg;

  // Segment vector, bit 6 = a ... bit 0 = g, 1 = segment lit.
  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = 7'b0000000;

  // Glyphs for 0..9 followed by A b C d E F.
  localparam seg_code_t SEG_CODE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg_code_t seg7_lookup(input logic [3:0] val);
    return SEG_CODE[val];
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Nibble to active-high 7-segment code, with a flag for displayable values.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_hex_en,
  output logic [6:0] o_code,
  output logic       o_valid
);

  // Decimal digits are always shown; 10..15 only when hex display is enabled.
  always_comb begin
    o_valid = (i_val < 4'd10) || i_hex_en;
    o_code  = o_valid ? seg7_lookup(i_val) : SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-wide 7-segment driver with one-hot anode scanning.
// Latency: outputs registered, one cycle behind the internal scan state.
// Backpressure: none; load is accepted on any cycle it is asserted.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 100000,
  parameter int BLINK_FRAMES   = 256,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  input  logic                  hex_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // XOR masks that turn active-high internal values into pin polarity;
  // they are also the "everything off" pin values.
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (ACTIVE_LOW_SEG != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW_AN != 0) ? {DIGITS{1'b1}} : '0;

  // Scan state.
  logic [PW-1:0]        r_p;
  logic [KW-1:0]        r_k;
  logic [BW-1:0]        r_bcnt;
  logic                 r_blink_phase;

  // Shadow copies of the display contents.
  logic [4*DIGITS-1:0]  r_digits;
  logic [DIGITS-1:0]    r_dp;
  logic [DIGITS-1:0]    r_blink;

  // Output registers.
  logic [6:0]           r_seg;
  logic                 r_dp_out;
  logic [DIGITS-1:0]    r_an;
  logic                 r_frame_tick;

  logic                 w_p_last;
  logic                 w_k_last;
  logic                 w_frame_end;
  logic [3:0]           w_val;
  logic                 w_dp_sel;
  logic                 w_blink_sel;
  logic                 w_lz_sel;
  logic [DIGITS-1:0]    w_onehot;
  logic [DIGITS-1:0]    w_upper_zero;
  logic [6:0]           w_code;
  logic                 w_code_valid;
  logic                 w_blank;
  logic                 w_lit;
  logic [6:0]           w_seg_hi;
  logic                 w_dp_hi;
  logic [DIGITS-1:0]    w_an_hi;

  assign w_p_last    = (r_p == PW'(SCAN_DIV - 1));
  assign w_k_last    = (r_k == KW'(DIGITS - 1));
  assign w_frame_end = w_p_last && w_k_last;

  // Prescaler, slot index and blink phase; the phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p           <= '0;
      r_k           <= '0;
      r_bcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_p <= w_p_last ? '0 : r_p + PW'(1);
      if (w_p_last) begin
        r_k <= w_k_last ? '0 : r_k + KW'(1);
      end
      if (w_frame_end) begin
        if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
          r_bcnt        <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_bcnt <= r_bcnt + BW'(1);
        end
      end
    end
  end

  // Shadow registers capture on load at any point in the scan; reset wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_blink  <= '0;
    end else if (load) begin
      r_digits <= digits_in;
      r_dp     <= dp_in;
      r_blink  <= blink_mask;
    end
  end

  // Mark each digit position whose own nibble and all more significant nibbles are zero.
  always_comb begin
    logic acc;
    w_upper_zero = '0;
    acc          = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc             = acc && (r_digits[4*i +: 4] == 4'h0);
      w_upper_zero[i] = acc;
    end
  end

  // Select the attributes of the digit in the current slot.
  always_comb begin
    w_val       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blink_sel = 1'b0;
    w_lz_sel    = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_k == KW'(i)) begin
        w_val       = r_digits[4*i +: 4];
        w_dp_sel    = r_dp[i];
        w_blink_sel = r_blink[i];
        w_lz_sel    = w_upper_zero[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seg7_encode u_encode (
    .i_val    (w_val),
    .i_hex_en (hex_en),
    .o_code   (w_code),
    .o_valid  (w_code_valid)
  );

  // Blanking and dead time; digit 0 is exempt from leading-zero suppression.
  always_comb begin
    w_blank  = !w_code_valid
            || (blank_lz && (r_k != '0) && w_lz_sel)
            || (w_blink_sel && r_blink_phase);
    w_lit    = (r_p != '0) && !w_blank;
    w_seg_hi = w_lit ? w_code : SEG_BLANK;
    w_dp_hi  = w_lit && w_dp_sel;
    w_an_hi  = w_lit ? w_onehot : '0;
  end

  // Register pin values in drive polarity; frame_tick marks the last cycle of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= SEG_OFF;
      r_dp_out     <= DP_OFF;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_hi ^ SEG_OFF;
      r_dp_out     <= w_dp_hi ^ DP_OFF;
      r_an         <= w_an_hi ^ AN_OFF;
      r_frame_tick <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp_out;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule
